csa_final_adder: RTL

CSA_FINAL_ADDER -- requirements
Module: csa_final_adder

---
 rtl/csa_final_adder.sv | 102 ++++++++++
 1 files changed

// File: rtl/csa_final_adder.sv
// Two-stage carry-propagate adder that resolves a carry-save (sum, carry) pair
// into a binary product plus carry-out, with valid/ready flow control on both sides.
module csa_final_adder #(
    parameter int WIDTH = 16    // even and >= 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_sum_vec,
    input  logic [WIDTH-1:0] i_carry_vec,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_product,
    output logic             o_overflow
);
    localparam int HALF = WIDTH / 2;

    // Stage S1: low-half result, mid carry and untouched upper halves
    logic            r_s1_valid;
    logic [HALF-1:0] r_s1_lo_sum;
    logic            r_s1_mid_carry;
    logic [HALF-1:0] r_s1_sum_hi;
    logic [HALF-1:0] r_s1_carry_hi;

    // Stage S2: final result
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_product;
    logic             r_overflow;

    logic w_s2_adv;
    logic w_s1_adv;

    logic [HALF:0]   w_lo_c;
    logic [HALF-1:0] w_lo_s;
    logic [HALF:0]   w_hi_c;
    logic [HALF-1:0] w_hi_s;

    assign w_s2_adv = ~r_s2_valid | i_out_ready;
    assign w_s1_adv = ~r_s1_valid | w_s2_adv;

    // Each half is a plain ripple chain; splitting at the midpoint halves the carry path per stage.
    assign w_lo_c[0] = 1'b0;
    assign w_hi_c[0] = r_s1_mid_carry;

    for (genvar gi = 0; gi < HALF; gi++) begin : g_lo_bit
        logic w_a;
        logic w_b;
        assign w_a           = i_sum_vec[gi];
        assign w_b           = i_carry_vec[gi];
        assign w_lo_s[gi]    = w_a ^ w_b ^ w_lo_c[gi];
        assign w_lo_c[gi+1]  = (w_a & w_b) | (w_a & w_lo_c[gi]) | (w_b & w_lo_c[gi]);
    end

    for (genvar gi = 0; gi < HALF; gi++) begin : g_hi_bit
        logic w_a;
        logic w_b;
        assign w_a           = r_s1_sum_hi[gi];
        assign w_b           = r_s1_carry_hi[gi];
        assign w_hi_s[gi]    = w_a ^ w_b ^ w_hi_c[gi];
        assign w_hi_c[gi+1]  = (w_a & w_b) | (w_a & w_hi_c[gi]) | (w_b & w_hi_c[gi]);
    end

    // Data registers only load with a valid item, so the product stays 0 until the first result.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s1_valid     <= 1'b0;
            r_s1_lo_sum    <= '0;
            r_s1_mid_carry <= 1'b0;
            r_s1_sum_hi    <= '0;
            r_s1_carry_hi  <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= i_in_valid;
            if (i_in_valid) begin
                r_s1_lo_sum    <= w_lo_s;
                r_s1_mid_carry <= w_lo_c[HALF];
                r_s1_sum_hi    <= i_sum_vec[WIDTH-1:HALF];
                r_s1_carry_hi  <= i_carry_vec[WIDTH-1:HALF];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s2_valid <= 1'b0;
            r_product  <= '0;
            r_overflow <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_product  <= {w_hi_s, r_s1_lo_sum};
                r_overflow <= w_hi_c[HALF];
            end
        end
    end

    assign o_in_ready  = w_s1_adv;
    assign o_out_valid = r_s2_valid;
    assign o_product   = r_product;
    assign o_overflow  = r_overflow;

endmodule
